fx1_pipe_ctrl: RTL and testbench

Issue-to-writeback pipeline controller for the FX1 simple-fixed-point unit of the SPU even pipe. Accepts one issued FX1 instruction per cycle and latches its operands. Drives the combinational FX1 ALU, carries the result and destination tag through a configurable-depth result pipeline, and presents per-stage forwarding taps and a single writeback port. Supports global stall (hold) and flush (kill) from the issue/branch logic.

---
 rtl/fx1_pipe_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fx1_pipe_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx1_pipe_ctrl.sv
// fx1_pipe_ctrl: issue-to-writeback pipeline controller for the FX1
// simple-fixed-point unit (SPU even pipe).
//
// S0 latches the issued operands and drives the combinational FX1 ALU.
// S1..S(LATENCY-1) carry the ALU result and destination tag to the single
// writeback port. Every stage exposes a forwarding tap.
//
// Optional feature macro: FX1_PERF_CNT_EN adds the saturating op_count
// output, which counts accepted issues.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   issue_*               issue request, operands, immediate, dest tag
//   issue_ready           combinational, !stall
//   stall, flush          global hold / kill from issue and branch logic
//   alu_*                 operand/immediate drive to the ALU, result back
//   fwd_valid/rt/data     per-stage forwarding taps (tap k = stage Sk)
//   wb_valid/rt/data      writeback port, combinational from the last stage
//   busy                  any stage holds a valid entry
//   op_count              accepted-issue counter (FX1_PERF_CNT_EN only)
module fx1_pipe_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [6:0]                  issue_instr_id,
  input  logic [6:0]                  issue_rt_addr,
  input  logic                        issue_reg_wr,
  input  logic [127:0]                issue_ra,
  input  logic [127:0]                issue_rb,
  input  logic [127:0]                issue_rc,
  input  logic [17:0]                 issue_imm,
  input  logic                        stall,
  input  logic                        flush,
  output logic [6:0]                  alu_instr_id,
  output logic [127:0]                alu_ra,
  output logic [127:0]                alu_rb,
  output logic [127:0]                alu_rc,
  output logic [6:0]                  alu_imme7,
  output logic [9:0]                  alu_imme10,
  output logic [15:0]                 alu_imme16,
  output logic [17:0]                 alu_imme18,
  input  logic [127:0]                alu_result,
  output logic [LATENCY-1:0]          fwd_valid,
  output logic [7*LATENCY-1:0]        fwd_rt_addr,
  output logic [128*LATENCY-1:0]      fwd_data,
  output logic                        wb_valid,
  output logic [6:0]                  wb_rt_addr,
  output logic [127:0]                wb_data,
  output logic                        busy
`ifdef FX1_PERF_CNT_EN
  ,
  output logic [31:0]                 op_count
`endif
);

  localparam int unsigned RT_W   = 7;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned NRES   = LATENCY - 1;

  // Operand stage S0
  logic              s0_valid;
  logic [6:0]        s0_id;
  logic [RT_W-1:0]   s0_rt;
  logic              s0_reg_wr;
  logic [DATA_W-1:0] s0_ra;
  logic [DATA_W-1:0] s0_rb;
  logic [DATA_W-1:0] s0_rc;
  logic [17:0]       s0_imm;

  // Result stages S1..S(LATENCY-1)
  logic              res_valid  [1:NRES];
  logic              res_reg_wr [1:NRES];
  logic [RT_W-1:0]   res_rt     [1:NRES];
  logic [DATA_W-1:0] res_data   [1:NRES];

  logic [LATENCY-1:0] stage_valid;

  assign issue_ready = !stall;

  // Operand register: loads the accepted issue, or bubbles on an idle edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid  <= 1'b0;
      s0_id     <= '0;
      s0_rt     <= '0;
      s0_reg_wr <= 1'b0;
      s0_ra     <= '0;
      s0_rb     <= '0;
      s0_rc     <= '0;
      s0_imm    <= '0;
    end else if (flush) begin
      s0_valid <= 1'b0;
    end else if (!stall) begin
      s0_valid <= issue_valid;
      if (issue_valid) begin
        s0_id     <= issue_instr_id;
        s0_rt     <= issue_rt_addr;
        s0_reg_wr <= issue_reg_wr;
        s0_ra     <= issue_ra;
        s0_rb     <= issue_rb;
        s0_rc     <= issue_rc;
        s0_imm    <= issue_imm;
      end
    end
  end

  // ALU drive; immediates are big-endian [0:n], so each field is the low bits
  assign alu_instr_id = s0_id;
  assign alu_ra       = s0_ra;
  assign alu_rb       = s0_rb;
  assign alu_rc       = s0_rc;
  assign alu_imme18   = s0_imm;
  assign alu_imme16   = s0_imm[15:0];
  assign alu_imme10   = s0_imm[9:0];
  assign alu_imme7    = s0_imm[6:0];

  // Tap 0 forwards the live ALU output for the op sitting in S0
  assign stage_valid[0]              = s0_valid;
  assign fwd_valid[0]                = s0_valid & s0_reg_wr;
  assign fwd_rt_addr[RT_W-1:0]       = s0_rt;
  assign fwd_data[DATA_W-1:0]        = alu_result;

  for (genvar k = 1; k < LATENCY; k++) begin : g_res
    logic              src_valid;
    logic              src_reg_wr;
    logic [RT_W-1:0]   src_rt;
    logic [DATA_W-1:0] src_data;

    // S1 captures the ALU result; later stages shift from their predecessor
    if (k == 1) begin : g_head
      assign src_valid  = s0_valid;
      assign src_reg_wr = s0_reg_wr;
      assign src_rt     = s0_rt;
      assign src_data   = alu_result;
    end else begin : g_tail
      assign src_valid  = res_valid[k-1];
      assign src_reg_wr = res_reg_wr[k-1];
      assign src_rt     = res_rt[k-1];
      assign src_data   = res_data[k-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        res_valid[k]  <= 1'b0;
        res_reg_wr[k] <= 1'b0;
        res_rt[k]     <= '0;
        res_data[k]   <= '0;
      end else if (flush) begin
        res_valid[k] <= 1'b0;
      end else if (!stall) begin
        res_valid[k]  <= src_valid;
        res_reg_wr[k] <= src_reg_wr;
        res_rt[k]     <= src_rt;
        res_data[k]   <= src_data;
      end
    end

    assign stage_valid[k]                  = res_valid[k];
    assign fwd_valid[k]                    = res_valid[k] & res_reg_wr[k];
    assign fwd_rt_addr[RT_W*k +: RT_W]     = res_rt[k];
    assign fwd_data[DATA_W*k +: DATA_W]    = res_data[k];
  end

  assign busy = |stage_valid;

  // A flush lets the retiring entry commit; reset discards it
  assign wb_valid   = res_valid[NRES] & res_reg_wr[NRES] & (!stall | flush) & !reset;
  assign wb_rt_addr = res_rt[NRES];
  assign wb_data    = res_data[NRES];

`ifdef FX1_PERF_CNT_EN
  logic [31:0] op_cnt;

  // Saturating count of accepted issues
  always_ff @(posedge clk) begin
    if (reset) begin
      op_cnt <= '0;
    end else if (issue_valid && !stall && !flush && (op_cnt != 32'hFFFF_FFFF)) begin
      op_cnt <= op_cnt + 32'd1;
    end
  end

  assign op_count = op_cnt;
`endif

endmodule

// File: tb/tb_fx1_pipe_ctrl.sv
// Scoreboard bench for fx1_pipe_ctrl: two instances (LATENCY 2 and 4) share
// one stimulus stream; each has its own ALU model, expected-op queue and
// cycle-timed reference model.
module tb_fx1_pipe_ctrl;

  localparam logic [6:0] ID_A    = 7'd1;
  localparam logic [6:0] ID_AI   = 7'd2;
  localparam logic [6:0] ID_SF   = 7'd3;
  localparam logic [6:0] ID_IOHL = 7'd4;
  localparam logic [6:0] ID_AND  = 7'd5;

  typedef struct {
    logic [6:0]   id;
    logic [6:0]   rt;
    logic         wr;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] rc;
    logic [17:0]  imm;
    logic [127:0] data;
    int           due;
  } op_t;

  logic         clk;
  logic         reset;
  logic         issue_valid;
  logic [6:0]   issue_instr_id;
  logic [6:0]   issue_rt_addr;
  logic         issue_reg_wr;
  logic [127:0] issue_ra;
  logic [127:0] issue_rb;
  logic [127:0] issue_rc;
  logic [17:0]  issue_imm;
  logic         stall;
  logic         flush;

  // Per-instance observations, padded to the 7-tap maximum
  logic [6:0]   fwd_v  [2];
  logic [48:0]  fwd_r  [2];
  logic [895:0] fwd_d  [2];
  logic         wb_v   [2];
  logic [6:0]   wb_r   [2];
  logic [127:0] wb_d   [2];
  logic         rdy    [2];
  logic         bsy    [2];
  logic [6:0]   m_id   [2];
  logic [127:0] m_ra   [2];
  logic [127:0] m_rb   [2];
  logic [127:0] m_rc   [2];
  logic [50:0]  m_imm  [2];
  logic [31:0]  opc    [2];

  op_t          q      [2][$];
  logic [31:0]  mcnt   [2];
  int           cyc;
  int           n_cmp;
  int           n_bad;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Behavioural FX1 ALU: word-wise ops, unknown IDs return zero
  function automatic logic [127:0] alu_f(input logic [6:0] id, input logic [127:0] ra,
                                         input logic [127:0] rb, input logic [127:0] rc,
                                         input logic [9:0] i10, input logic [15:0] i16);
    logic [127:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      case (id)
        ID_A:    r[32*w +: 32] = ra[32*w +: 32] + rb[32*w +: 32];
        ID_AI:   r[32*w +: 32] = ra[32*w +: 32] + {{22{i10[9]}}, i10};
        ID_SF:   r[32*w +: 32] = rb[32*w +: 32] - ra[32*w +: 32];
        ID_IOHL: r[32*w +: 32] = rc[32*w +: 32] | {16'h0, i16};
        ID_AND:  r[32*w +: 32] = ra[32*w +: 32] & rb[32*w +: 32];
        default: r[32*w +: 32] = 32'h0;
      endcase
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : 4;
    logic [6:0]     a_id;
    logic [127:0]   a_ra, a_rb, a_rc, a_res;
    logic [6:0]     a_i7;
    logic [9:0]     a_i10;
    logic [15:0]    a_i16;
    logic [17:0]    a_i18;
    logic [L-1:0]   fv;
    logic [7*L-1:0] fr;
    logic [128*L-1:0] fd;
    logic           wv, rd, bz;
    logic [6:0]     wr;
    logic [127:0]   wd;
    logic [31:0]    oc;

    assign a_res = alu_f(a_id, a_ra, a_rb, a_rc, a_i10, a_i16);

    fx1_pipe_ctrl #(.LATENCY(L)) u_dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(rd),
      .issue_instr_id(issue_instr_id), .issue_rt_addr(issue_rt_addr),
      .issue_reg_wr(issue_reg_wr), .issue_ra(issue_ra), .issue_rb(issue_rb),
      .issue_rc(issue_rc), .issue_imm(issue_imm),
      .stall(stall), .flush(flush),
      .alu_instr_id(a_id), .alu_ra(a_ra), .alu_rb(a_rb), .alu_rc(a_rc),
      .alu_imme7(a_i7), .alu_imme10(a_i10), .alu_imme16(a_i16), .alu_imme18(a_i18),
      .alu_result(a_res),
      .fwd_valid(fv), .fwd_rt_addr(fr), .fwd_data(fd),
      .wb_valid(wv), .wb_rt_addr(wr), .wb_data(wd),
      .busy(bz)
`ifdef FX1_PERF_CNT_EN
      , .op_count(oc)
`endif
    );

`ifndef FX1_PERF_CNT_EN
    assign oc = 32'h0;
`endif

    assign fwd_v[g] = 7'(fv);
    assign fwd_r[g] = 49'(fr);
    assign fwd_d[g] = 896'(fd);
    assign wb_v[g]  = wv;
    assign wb_r[g]  = wr;
    assign wb_d[g]  = wd;
    assign rdy[g]   = rd;
    assign bsy[g]   = bz;
    assign m_id[g]  = a_id;
    assign m_ra[g]  = a_ra;
    assign m_rb[g]  = a_rb;
    assign m_rc[g]  = a_rc;
    assign m_imm[g] = {a_i7, a_i10, a_i16, a_i18};
    assign opc[g]   = oc;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int i, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL L%0d %s: got %0h, expected %0h (cycle %0d)", lat_of(i), nm, act, exp, cyc);
    end
  endtask

  // Reference model: each op becomes visible at writeback LATENCY-1 edges after
  // acceptance, plus one edge per stall; flush and reset empty the pipe.
  initial begin : model
    op_t e;
    logic acc;
    cyc = 0;
    mcnt[0] = 32'h0;
    mcnt[1] = 32'h0;
    forever begin
      @(posedge clk);
      acc = issue_valid && !stall && !flush && !reset;
      e.id  = issue_instr_id;
      e.rt  = issue_rt_addr;
      e.wr  = issue_reg_wr;
      e.ra  = issue_ra;
      e.rb  = issue_rb;
      e.rc  = issue_rc;
      e.imm = issue_imm;
      e.data = alu_f(issue_instr_id, issue_ra, issue_rb, issue_rc, issue_imm[9:0], issue_imm[15:0]);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          q[i].delete();
          mcnt[i] = 32'h0;
        end else if (flush) begin
          q[i].delete();
        end else if (stall) begin
          for (int j = 0; j < q[i].size(); j++) q[i][j].due = q[i][j].due + 1;
        end else begin
          while (q[i].size() > 0 && q[i][0].due <= cyc) void'(q[i].pop_front());
        end
        if (acc) begin
          e.due = cyc + lat_of(i);
          q[i].push_back(e);
          if (mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 32'd1;
        end
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: checks taps, busy, ready and ALU drive; pops on writeback
  initial begin : monitor
    logic [6:0]   efv;
    logic [48:0]  efr;
    logic [895:0] efd;
    logic         ewb;
    int           st, li;
    op_t          f;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < 2; i++) begin
          li  = lat_of(i);
          efv = '0;
          efr = '0;
          efd = '0;
          for (int j = 0; j < q[i].size(); j++) begin
            st = li - 1 - (q[i][j].due - cyc);
            if (st >= 0 && st < li) begin
              if (q[i][j].wr) begin
                efv[st] = 1'b1;
                efr[7*st +: 7] = q[i][j].rt;
                efd[128*st +: 128] = q[i][j].data;
              end
              if (st == 0) begin
                chk(i, "alu_instr_id", 256'(m_id[i]), 256'(q[i][j].id));
                chk(i, "alu_ra", 256'(m_ra[i]), 256'(q[i][j].ra));
                chk(i, "alu_rb", 256'(m_rb[i]), 256'(q[i][j].rb));
                chk(i, "alu_rc", 256'(m_rc[i]), 256'(q[i][j].rc));
                chk(i, "alu_imme7/10/16/18", 256'(m_imm[i]),
                    256'({q[i][j].imm[6:0], q[i][j].imm[9:0], q[i][j].imm[15:0], q[i][j].imm}));
              end
            end
          end
          chk(i, "fwd_valid", 256'(fwd_v[i]), 256'(efv));
          for (int k = 0; k < li; k++) begin
            if (efv[k]) begin
              chk(i, $sformatf("fwd_rt_addr tap%0d", k), 256'(fwd_r[i][7*k +: 7]), 256'(efr[7*k +: 7]));
              chk(i, $sformatf("fwd_data tap%0d", k), 256'(fwd_d[i][128*k +: 128]), 256'(efd[128*k +: 128]));
            end
          end
          chk(i, "busy", 256'(bsy[i]), 256'(q[i].size() != 0));
          chk(i, "issue_ready", 256'(rdy[i]), 256'(!stall));
`ifdef FX1_PERF_CNT_EN
          chk(i, "op_count", 256'(opc[i]), 256'(mcnt[i]));
`endif
          ewb = (q[i].size() > 0) && (q[i][0].due == cyc) && q[i][0].wr && (!stall || flush) && !reset;
          chk(i, "wb_valid", 256'(wb_v[i]), 256'(ewb));
          if (wb_v[i]) begin
            if (q[i].size() == 0) begin
              chk(i, "wb with empty scoreboard", 256'(1), 256'(0));
            end else begin
              f = q[i].pop_front();
              chk(i, "wb_rt_addr", 256'(wb_r[i]), 256'(f.rt));
              chk(i, "wb_data", 256'(wb_d[i]), 256'(f.data));
              chk(i, "wb cycle", 256'(cyc), 256'(f.due));
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_op(input logic [6:0] id, input logic [6:0] rt, input logic wr,
                          input logic [127:0] ra, input logic [127:0] rb,
                          input logic [127:0] rc, input logic [17:0] imm);
    issue_valid    = 1'b1;
    issue_instr_id = id;
    issue_rt_addr  = rt;
    issue_reg_wr   = wr;
    issue_ra       = ra;
    issue_rb       = rb;
    issue_rc       = rc;
    issue_imm      = imm;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : stim
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    issue_op(ID_A, 7'd0, 1'b0, '0, '0, '0, '0);
    issue_valid = 1'b0;
    step(1);
    stall = 1'b1;
    step(1);
    stall = 1'b0;
    reset = 1'b0;
    step(2);

    // Basic add: 5 + 7 into rt 3
    issue_op(ID_A, 7'd3, 1'b1, 128'd5, 128'd7, '0, '0);
    step(1);
    issue_valid = 1'b0;
    step(5);

    // Immediate slicing: ai with imm 0x3FF adds -1
    issue_op(ID_AI, 7'd9, 1'b1, 128'd1, '0, '0, 18'h003FF);
    step(1);
    issue_valid = 1'b0;
    step(5);

    // Back-to-back stream rt 1..4
    for (int n = 1; n <= 4; n++) begin
      issue_op(ID_SF, 7'(n), 1'b1, rnd128(), rnd128(), rnd128(), 18'(n));
      step(1);
    end
    issue_valid = 1'b0;
    step(6);

    // Stream with a 3-cycle stall in the middle
    for (int n = 1; n <= 5; n++) begin
      if (n == 3) begin
        stall = 1'b1;
        issue_op(ID_IOHL, 7'd77, 1'b1, rnd128(), rnd128(), rnd128(), 18'h2ABCD);
        step(3);
        stall = 1'b0;
      end
      issue_op(ID_IOHL, 7'(10 + n), 1'b1, rnd128(), rnd128(), rnd128(), 18'($urandom));
      step(1);
    end
    issue_valid = 1'b0;
    step(8);

    // Flush with stall while S1 retires and S0 is valid; offered issue is dropped
    issue_op(ID_A, 7'd21, 1'b1, rnd128(), rnd128(), '0, '0);
    step(1);
    issue_op(ID_AND, 7'd22, 1'b1, rnd128(), rnd128(), '0, '0);
    step(1);
    flush = 1'b1;
    stall = 1'b1;
    issue_op(ID_A, 7'd23, 1'b1, rnd128(), rnd128(), '0, '0);
    step(1);
    flush = 1'b0;
    stall = 1'b0;
    issue_valid = 1'b0;
    step(6);

    // Reset with three ops in flight
    for (int n = 0; n < 3; n++) begin
      issue_op(ID_A, 7'(40 + n), 1'b1, rnd128(), rnd128(), '0, '0);
      step(1);
    end
    issue_valid = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);

    // Randomised traffic, including unknown IDs and non-writing ops
    for (int c = 0; c < 1500; c++) begin
      issue_op(7'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
               ($urandom_range(0, 99) < 80), rnd128(), rnd128(), rnd128(), 18'($urandom));
      issue_valid = ($urandom_range(0, 99) < 70);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    issue_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
